// File: rtl/seq_chunk_adder_pkg.sv
// Shared constants and FSM encoding for the chunked sequential adder.
// Optional subtract mode is enabled with SEQ_CHUNK_ADDER_SUB_EN.
package seq_chunk_adder_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_CHUNK = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Request/result bundle of the chunked sequential adder.
// The sub signal exists only when SEQ_CHUNK_ADDER_SUB_EN is defined.
interface seq_chunk_adder_if
   import seq_chunk_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             cin;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
   modport master (
      output start, x, y, cin, sub,
      input  busy, done, sum, cout
   );
   modport slave (
      input  start, x, y, cin, sub,
      output busy, done, sum, cout
   );
`else
   modport master (
      output start, x, y, cin,
      input  busy, done, sum, cout
   );
   modport slave (
      input  start, x, y, cin,
      output busy, done, sum, cout
   );
`endif

endinterface

// File: rtl/seq_chunk_adder_chunk_rca.sv
// CHUNK-bit ripple-carry full-adder chain, purely combinational.
module chunk_rca #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co
);

   logic [CHUNK:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < CHUNK; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      co = c[CHUNK];
   end

endmodule

// File: rtl/seq_chunk_adder.sv
// Sequential adder: one CHUNK-bit slice per cycle through a shared RCA.
// Define SEQ_CHUNK_ADDER_SUB_EN to add the sub (x - y) request bit.
module seq_chunk_adder
   import seq_chunk_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   seq_chunk_adder_if.slave bus
);

   localparam int N  = WIDTH / CHUNK;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
   end

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nx;
   logic [WIDTH-1:0] sum_q;
   logic [IW-1:0]    idx;
   logic             carry;
   logic             cout_q;
   logic             busy_q;
   logic             done_q;
   logic [CHUNK-1:0] a_ch;
   logic [CHUNK-1:0] b_ch;
   logic [CHUNK-1:0] s_ch;
   logic             co;
   logic             last;
   logic [WIDTH-1:0] b_in;
   logic             c_in;
   logic [WIDTH-1:0] mask;
   int               sh;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
   // x - y as x + ~y + 1; cout then reads as "no borrow"
   assign b_in = bus.sub ? ~bus.y : bus.y;
   assign c_in = bus.sub ? 1'b1 : bus.cin;
`else
   assign b_in = bus.y;
   assign c_in = bus.cin;
`endif

   assign sh   = int'(idx) * CHUNK;
   assign a_ch = CHUNK'(a_q >> sh);
   assign b_ch = CHUNK'(b_q >> sh);
   assign mask = WIDTH'({CHUNK{1'b1}}) << sh;
   assign last = (idx == IW'(N - 1));

   chunk_rca #(.CHUNK(CHUNK)) u_rca (
      .a  (a_ch),
      .b  (b_ch),
      .ci (carry),
      .s  (s_ch),
      .co (co)
   );

   always_comb begin
      acc_nx = (acc & ~mask) | (WIDTH'(s_ch) << sh);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         acc    <= '0;
         sum_q  <= '0;
         idx    <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_q    <= bus.x;
                  b_q    <= b_in;
                  carry  <= c_in;
                  idx    <= '0;
                  acc    <= '0;
                  state  <= RUN;
                  busy_q <= 1'b1;
               end else begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            RUN: begin
               acc   <= acc_nx;
               carry <= co;
               idx   <= idx + IW'(1);
               if (last) begin
                  sum_q  <= acc_nx;
                  cout_q <= co;
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder (16/4 main instance, 8/8 corner).
// Exercises subtract mode too when SEQ_CHUNK_ADDER_SUB_EN is defined.
module tb_seq_chunk_adder;
   import seq_chunk_adder_pkg::*;

   localparam int W = 16;
   localparam int C = 4;
   localparam int N = W / C;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif

   typedef struct {
      logic [W:0] res;
      int         due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   passed = 0;
   int   total = 0;
   exp_t q[$];
   logic [W:0] held = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   seq_chunk_adder_if #(.WIDTH(W)) bus ();
   seq_chunk_adder_if #(.WIDTH(8)) bus8 ();

   seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)",
                    name, act, exp, cyc);
   endtask

   // Plain integer arithmetic: bit W of the result is the carry-out
   function automatic logic [W:0] model(input logic [W-1:0] a, b,
                                        input logic c, s);
      longint unsigned r;
      if (s) r = longint'(a) + (longint'(1) << W) - longint'(b);
      else   r = longint'(a) + longint'(b) + longint'(c);
      return r[W:0];
   endfunction

   task automatic issue(input logic [W-1:0] a, b, input logic c, s);
      exp_t e;
      bus.start = 1'b1;
      bus.x     = a;
      bus.y     = b;
      bus.cin   = c;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
      bus.sub   = s;
`endif
      e.res = model(a, b, c, s);
      e.due = cyc + 1 + N;
      q.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic poke_busy();
      bus.start = 1'b1;
      bus.x     = W'($urandom);
      bus.y     = W'($urandom);
      bus.cin   = 1'($urandom);
`ifdef SEQ_CHUNK_ADDER_SUB_EN
      bus.sub   = 1'($urandom);
`endif
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_free();
      int n = 0;
      while (bus.busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("wait_free", 32'(bus.busy), 0);
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.done && n < 200);
      chk("wait_done", 32'(bus.done), 1);
   endtask

   // Monitor: result checks on done, hold checks while busy
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.busy) begin
            chk("hold_sum", 32'(bus.sum), 32'(held[W-1:0]));
            chk("hold_cout", 32'(bus.cout), 32'(held[W]));
         end
         if (q.size() != 0 && cyc == q[0].due)
            chk("done_on_time", 32'(bus.done), 1);
         if (bus.done) begin
            chk("done_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
               exp_t e;
               e = q.pop_front();
               chk("sum", 32'(bus.sum), 32'(e.res[W-1:0]));
               chk("cout", 32'(bus.cout), 32'(e.res[W]));
               chk("latency", 32'(cyc), 32'(e.due));
               chk("busy_at_done", 32'(bus.busy), 0);
               held = e.res;
            end
         end
      end
   end

   initial begin
      logic [W-1:0] a, b;
      logic         c, s;
      bus.start  = 1'b0;
      bus.x      = '0;
      bus.y      = '0;
      bus.cin    = 1'b0;
      bus8.start = 1'b0;
      bus8.x     = '0;
      bus8.y     = '0;
      bus8.cin   = 1'b0;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
      bus.sub    = 1'b0;
      bus8.sub   = 1'b0;
`endif
      #1 rst = 1'b1;
      #2;
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_sum", 32'(bus.sum), 0);
      chk("rst_cout", 32'(bus.cout), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      issue(16'h1234, 16'h0001, 1'b0, 1'b0);
      wait_done();

      wait_free();
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_done();
      issue(16'h000F, 16'h0001, 1'b1, 1'b0);
      wait_done();

      wait_free();
      issue(16'h0100, 16'h0200, 1'b0, 1'b0);
      poke_busy();
      wait_done();

      // Abandon a run after its second processing edge
      wait_free();
      issue(16'h1111, 16'h2222, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      q.delete();
      held = '0;
      #1;
      chk("midrun_rst_busy", 32'(bus.busy), 0);
      chk("midrun_rst_done", 32'(bus.done), 0);
      chk("midrun_rst_sum", 32'(bus.sum), 0);
      chk("midrun_rst_cout", 32'(bus.cout), 0);
      @(negedge clk);
      rst = 1'b0;
      issue(16'h0003, 16'h0004, 1'b0, 1'b0);
      wait_done();

      if (SUB_EN) begin
         wait_free();
         issue(16'h0005, 16'h0007, 1'b0, 1'b1);
         wait_done();
         issue(16'h0007, 16'h0005, 1'b1, 1'b1);
         wait_done();
      end

      for (int i = 0; i < 60; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         c = 1'($urandom);
         s = SUB_EN ? 1'($urandom) : 1'b0;
         if ($urandom_range(0, 2) == 0) begin
            wait_done();
         end else begin
            wait_free();
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         issue(a, b, c, s);
         if ($urandom_range(0, 3) == 0) poke_busy();
      end
      wait_free();
      repeat (3) @(negedge clk);
      chk("drain", 32'(q.size()), 0);

      // Single-chunk instance: one edge from accept to done
      bus8.x     = 8'hC8;
      bus8.y     = 8'h64;
      bus8.cin   = 1'b0;
      bus8.start = 1'b1;
      @(negedge clk);
      bus8.start = 1'b0;
      chk("w8_busy", 32'(bus8.busy), 1);
      @(negedge clk);
      chk("w8_done", 32'(bus8.done), 1);
      chk("w8_sum", 32'(bus8.sum), 32'h2C);
      chk("w8_cout", 32'(bus8.cout), 1);
      @(negedge clk);
      chk("w8_done_pulse", 32'(bus8.done), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/seq_chunk_adder.md
SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK (elaboration error otherwise).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-006 SHALL have port x  input  WIDTH  operand A, sampled on accepting edge only.
REQ-007 SHALL have port y  input  WIDTH  operand B, sampled on accepting edge only.
REQ-008 SHALL have port cin  input  1  carry-in, sampled on accepting edge only.
REQ-009 SHALL have port busy  output  1  high while in RUN state.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking a new valid result.
REQ-011 SHALL have port sum  output  WIDTH  result register.
REQ-012 SHALL have port cout  output  1  final carry-out register.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-014 IDLE or DONE with start=1 at edge E0 SHALL latch x, y, cin into internal registers, clear chunk index to 0, and enter RUN.
REQ-015 In RUN, each edge SHALL add chunk idx (bits idx*CHUNK+CHUNK-1 : idx*CHUNK) of the latched operands plus the carry register, store the CHUNK-bit partial into the internal accumulator, and update the carry register.
REQ-016 The carry register SHALL be loaded with latched cin at E0 and propagate chunk to chunk; no carry leaks between operations.
REQ-017 After the edge that processes chunk WIDTH/CHUNK-1 (edge E_N, N=WIDTH/CHUNK), sum SHALL equal the full accumulator, cout SHALL equal the final carry, and the state SHALL be DONE.
REQ-018 Latency SHALL be exactly N edges from accepting edge to done high; CHUNK=WIDTH gives latency 1.
REQ-019 DONE SHALL last one cycle, then go to IDLE unless start=1 (REQ-014 applies: back-to-back ops allowed, no idle gap).
REQ-020 start=1 while busy=1 SHALL be ignored: no operand re-latch, no index change.
REQ-021 sum and cout SHALL hold the previous result throughout RUN and IDLE; partial sums SHALL never appear on sum.
REQ-022 Result arithmetic SHALL be modulo 2^WIDTH with cout as bit WIDTH of x+y+cin.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, index=0, carry=0, independent of clk.
REQ-024 rst asserted mid-RUN SHALL abandon the operation; no done pulse SHALL follow for it.
REQ-025 First start accepted on the first edge after rst deasserts.

Configuration
REQ-026 Macro SEQ_CHUNK_ADDER_SUB_EN defined: extra port sub input 1, sampled with operands; sub=1 computes x + ~y + 1 (cin ignored), cout=1 meaning no borrow; sub=0 as REQ-022.
REQ-027 Macro undefined: no sub port, add-only behaviour, identical timing.

Structure
REQ-028 Package seq_chunk_adder_pkg SHALL hold the state encoding constants (IDLE, RUN, DONE) and default WIDTH/CHUNK constants.
REQ-029 Sub-module chunk_rca (combinational CHUNK-bit ripple-carry full-adder chain: a, b, ci -> s, co) SHALL be instantiated once and reused per cycle.

Verification (WIDTH=16, CHUNK=4 unless noted)
REQ-030 x=0x1234, y=0x0001, cin=0, start pulse -> busy 4 cycles, done at 4th edge, sum=0x1235, cout=0.
REQ-031 x=0xFFFF, y=0x0001, cin=0 -> sum=0x0000, cout=1 (carry through all chunks); then x=0x000F, y=0x0001, cin=1 started in the DONE cycle -> sum=0x0011, cout=0, no idle gap.
REQ-032 start pulsed again mid-RUN with different operands -> ignored; result matches first operands, single done.
REQ-033 rst asserted at edge 2 of RUN -> all outputs 0 immediately, no done; next op 0x0003+0x0004 -> 0x0007.
REQ-034 With SEQ_CHUNK_ADDER_SUB_EN, sub=1, x=0x0005, y=0x0007 -> sum=0xFFFE, cout=0; x=0x0007, y=0x0005 -> sum=0x0002, cout=1.
REQ-035 WIDTH=8, CHUNK=8: x=0xC8, y=0x64, cin=0 -> done after 1 edge, sum=0x2C, cout=1.
